mem_port_arbiter: RTL

Shares one single-ported synchronous RAM port (1-cycle read latency, DataMemory-style byte-enable/funct3 interface) between the PipelinedCPU instruction-fetch requester and data requester. It arbitrates with data priority plus an anti-starvation override, registers the winning command onto the memory port, and routes read data back to the owner. It sits between PipelinedCPU and a unified memory, in place of separate InstructionMemory/DataMemory ports.

---
 rtl/mem_port_arbiter_pkg.sv | 56 +++++
 rtl/mem_port_arbiter_starve_ctr.sv | 34 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: owner tags, command payload
// and the arbitration priority function.
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ALEN = 32;
    localparam int unsigned BE_W = 4;
    localparam int unsigned F3_W = 3;

    localparam logic [F3_W-1:0] F3_LW = 3'b010;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } mem_owner_e;

    typedef struct packed {
        logic [ALEN-1:0] addr;
        logic            we;
        logic [BE_W-1:0] be;
        logic [F3_W-1:0] funct3;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // Data normally wins; a starved fetch overrides it.
    function automatic mem_owner_e arb_pick(
        input logic force_i,
        input logic i_valid,
        input logic d_valid
    );
        mem_owner_e win;
        win = OWN_NONE;
        if (force_i && i_valid) begin
            win = OWN_I;
        end else if (d_valid) begin
            win = OWN_D;
        end else if (i_valid) begin
            win = OWN_I;
        end
        return win;
    endfunction

    function automatic mem_owner_e drop_fetch(
        input mem_owner_e tag,
        input logic       flush
    );
        mem_owner_e res;
        res = tag;
        if (flush && (tag == OWN_I)) begin
            res = OWN_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the fetch requester has been refused;
// raises o_force_c once the count reaches STARVE_LIMIT (0 disables).
module mem_port_arbiter_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_valid,
    input  logic i_blocked,
    output logic o_force_c
);

    localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_req_valid && i_blocked) begin
            if (r_cnt < LIMIT) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_force_c = (STARVE_LIMIT != 0) && (r_cnt >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 1-cycle-latency RAM port between instruction fetch and data access.
// Optional build macro ARB_STATS_EN adds grant/stall statistics counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [ALEN-1:0] i_addr,
    input  logic            i_flush,
    output logic            i_rvalid,
    output logic [31:0]     i_rdata,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [ALEN-1:0] d_addr,
    input  logic            d_we,
    input  logic [BE_W-1:0] d_be,
    input  logic [F3_W-1:0] d_funct3,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,
    output logic            m_en,
    output logic [ALEN-1:0] m_addr,
    output logic            m_we,
    output logic [BE_W-1:0] m_be,
    output logic [F3_W-1:0] m_funct3,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_i_grants,
    output logic [CNT_W-1:0] stat_d_grants,
    output logic [CNT_W-1:0] stat_i_stall
`endif
);

    mem_owner_e w_win;
    mem_owner_e w_tag0_nxt;
    mem_owner_e w_tag1_nxt;
    mem_cmd_t   w_cmd;
    logic       w_force_c;
    logic       w_i_blocked;

    mem_cmd_t   r_cmd;
    logic       r_en;
    mem_owner_e r_tag0;
    mem_owner_e r_tag1;

    mem_port_arbiter_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_valid(i_req_valid),
        .i_blocked  (w_i_blocked),
        .o_force_c  (w_force_c)
    );

    always_comb begin
        w_win = arb_pick(w_force_c, i_req_valid, d_req_valid);
    end

    // Memory never back-pressures, so winning is the same as being accepted.
    assign i_req_ready = (w_win == OWN_I);
    assign d_req_ready = (w_win == OWN_D);
    assign w_i_blocked = i_req_valid && !i_req_ready;

    always_comb begin
        w_cmd = '0;
        if (w_win == OWN_D) begin
            w_cmd.addr   = d_addr;
            w_cmd.we     = d_we;
            w_cmd.be     = d_be;
            w_cmd.funct3 = d_funct3;
            w_cmd.wdata  = d_wdata;
        end else begin
            w_cmd.addr   = i_addr;
            w_cmd.funct3 = F3_LW;
        end
    end

    // A redirect kills fetch tags at both pipeline stages, including one won this cycle.
    always_comb begin
        w_tag0_nxt = drop_fetch(w_win, i_flush);
        w_tag1_nxt = drop_fetch(r_tag0, i_flush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en   <= 1'b0;
            r_cmd  <= '0;
            r_tag0 <= OWN_NONE;
            r_tag1 <= OWN_NONE;
        end else begin
            r_en   <= (w_win != OWN_NONE);
            r_tag0 <= w_tag0_nxt;
            r_tag1 <= w_tag1_nxt;
            if (w_win != OWN_NONE) begin
                r_cmd <= w_cmd;
            end else begin
                r_cmd.we <= 1'b0;
            end
        end
    end

    assign m_en     = r_en;
    assign m_addr   = r_cmd.addr;
    assign m_we     = r_cmd.we;
    assign m_be     = r_cmd.be;
    assign m_funct3 = r_cmd.funct3;
    assign m_wdata  = r_cmd.wdata;

    assign i_rvalid = (r_tag1 == OWN_I);
    assign d_rvalid = (r_tag1 == OWN_D);
    assign i_rdata  = m_rdata[31:0];
    assign d_rdata  = m_rdata;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_stat_i_grants;
    logic [CNT_W-1:0] r_stat_d_grants;
    logic [CNT_W-1:0] r_stat_i_stall;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_i_grants <= '0;
            r_stat_d_grants <= '0;
            r_stat_i_stall  <= '0;
        end else begin
            if (w_win == OWN_I) begin
                r_stat_i_grants <= r_stat_i_grants + CNT_W'(1);
            end
            if (w_win == OWN_D) begin
                r_stat_d_grants <= r_stat_d_grants + CNT_W'(1);
            end
            if (w_i_blocked) begin
                r_stat_i_stall <= r_stat_i_stall + CNT_W'(1);
            end
        end
    end

    assign stat_i_grants = r_stat_i_grants;
    assign stat_d_grants = r_stat_d_grants;
    assign stat_i_stall  = r_stat_i_stall;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W == 32'd0);
`endif

endmodule
